// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the async ROM address, and hands
// captured words to decode over a valid/ready handshake with jump, halt and wrap support.
module instr_fetch #(
    parameter int                    ROM_WIDTH  = 21,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [ROM_WIDTH-1:0]  rom_data,
    output logic [ROM_WIDTH-1:0]  ir,
    output logic [ADDR_WIDTH-1:0] ir_pc,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    input  logic                  jump_req,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    input  logic                  halt,
    output logic                  halted,
    output logic                  pc_wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  do_jump;
    logic                  do_fetch;
    logic                  slot_free;

    assign rom_addr  = pc;
    assign halted    = (state == HALT);
    assign slot_free = !ir_valid || ir_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Priority is halt > jump > fetch; the run level only gates fetching and the IDLE/RUN move.
    always_comb begin
        state_next = state;
        do_jump    = 1'b0;
        do_fetch   = 1'b0;
        case (state)
            IDLE: begin
                if (halt) begin
                    state_next = HALT;
                end else begin
                    if (run) begin
                        state_next = RUN;
                    end
                    do_jump = jump_req;
                end
            end
            RUN: begin
                if (halt) begin
                    state_next = HALT;
                end else begin
                    if (!run) begin
                        state_next = IDLE;
                    end
                    if (jump_req) begin
                        do_jump = 1'b1;
                    end else if (run && slot_free) begin
                        do_fetch = 1'b1;
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            pc_wrap  <= 1'b0;
        end else if (state_next == HALT) begin
            ir_valid <= 1'b0;
        end else if (do_jump) begin
            pc       <= jump_addr;
            ir_valid <= 1'b0;
        end else if (do_fetch) begin
            ir       <= rom_data;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            pc       <= pc + ADDR_WIDTH'(1);
            if (&pc) begin
                pc_wrap <= 1'b1;
            end
        end else if (ir_valid && ir_ready) begin
            // A consumed word with no replacement must not be presented twice.
            ir_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised and directed bench for instr_fetch: a behavioural model predicts each
// transfer into a scoreboard queue that a negedge monitor pops and compares.
module tb_instr_fetch;

    localparam int RW = 21;
    localparam int AW = 16;

    typedef struct {
        logic [AW-1:0] pc;
        logic [RW-1:0] word;
    } xfer_t;

    logic          clk;
    logic          rst_n;
    logic          run;
    logic [AW-1:0] rom_addr;
    logic [RW-1:0] rom_data;
    logic [RW-1:0] ir;
    logic [AW-1:0] ir_pc;
    logic          ir_valid;
    logic          ir_ready;
    logic          jump_req;
    logic [AW-1:0] jump_addr;
    logic          halt;
    logic          halted;
    logic          pc_wrap;

    int checks   = 0;
    int failures = 0;

    xfer_t expected_q[$];

    // Behavioural model of the visible state
    logic [AW-1:0] m_pc;
    logic [RW-1:0] m_ir;
    logic [AW-1:0] m_ir_pc;
    logic          m_valid;
    logic          m_halted;
    logic          m_wrap;
    logic          m_running;

    instr_fetch #(
        .ROM_WIDTH (RW),
        .ADDR_WIDTH(AW),
        .RESET_PC  (16'h0000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .ir       (ir),
        .ir_pc    (ir_pc),
        .ir_valid (ir_valid),
        .ir_ready (ir_ready),
        .jump_req (jump_req),
        .jump_addr(jump_addr),
        .halt     (halt),
        .halted   (halted),
        .pc_wrap  (pc_wrap)
    );

    function automatic logic [RW-1:0] rom_word(input logic [AW-1:0] a);
        return {a[4:0] ^ 5'h0B, a};
    endfunction

    assign rom_data = rom_word(rom_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_pc      = '0;
        m_ir      = '0;
        m_ir_pc   = '0;
        m_valid   = 1'b0;
        m_halted  = 1'b0;
        m_wrap    = 1'b0;
        m_running = 1'b0;
    endtask

    // One rising edge of the reference behaviour, given that cycle's inputs.
    task automatic modelStep(input logic r, input logic rd, input logic jq, input logic [AW-1:0] ja, input logic h);
        if (m_halted) begin
            m_valid = 1'b0;
        end else if (h) begin
            m_halted = 1'b1;
            m_valid  = 1'b0;
        end else begin
            if (jq) begin
                m_pc    = ja;
                m_valid = 1'b0;
            end else if (m_running && r && (!m_valid || rd)) begin
                m_ir    = rom_word(m_pc);
                m_ir_pc = m_pc;
                m_valid = 1'b1;
                if (m_pc == 16'hFFFF) m_wrap = 1'b1;
                m_pc = AW'((int'(m_pc) + 1) % 65536);
            end else if (m_valid && rd) begin
                m_valid = 1'b0;
            end
            m_running = r;
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic applyStimulus(input logic r, input logic rd, input logic jq, input logic [AW-1:0] ja, input logic h);
        xfer_t x;
        run       = r;
        ir_ready  = rd;
        jump_req  = jq;
        jump_addr = ja;
        halt      = h;
        if (m_valid && rd) begin
            x.pc   = m_ir_pc;
            x.word = m_ir;
            expected_q.push_back(x);
        end
        @(negedge clk);
        #1;
        modelStep(r, rd, jq, ja, h);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("reset rom_addr", 32'(rom_addr), 32'h0);
        checkOutput("reset ir_valid", 32'(ir_valid), 32'h0);
        checkOutput("reset halted", 32'(halted), 32'h0);
        checkOutput("reset pc_wrap", 32'(pc_wrap), 32'h0);
        checkOutput("reset ir", 32'(ir), 32'h0);
        checkOutput("reset ir_pc", 32'(ir_pc), 32'h0);
        modelReset();
        expected_q.delete();
        ir_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares live state every cycle and pops the scoreboard on each transfer.
    initial begin
        xfer_t x;
        forever begin
            @(negedge clk);
            checkOutput("rom_addr", 32'(rom_addr), 32'(m_pc));
            checkOutput("ir_valid", 32'(ir_valid), 32'(m_valid));
            checkOutput("halted", 32'(halted), 32'(m_halted));
            checkOutput("pc_wrap", 32'(pc_wrap), 32'(m_wrap));
            if (ir_valid && ir_ready) begin
                if (expected_q.size() == 0) begin
                    checkOutput("unexpected transfer", 32'(ir_pc), 32'hFFFF_FFFF);
                end else begin
                    x = expected_q.pop_front();
                    checkOutput("xfer ir_pc", 32'(ir_pc), 32'(x.pc));
                    checkOutput("xfer ir", 32'(ir), 32'(x.word));
                end
            end
        end
    end

    initial begin
        logic [AW-1:0] ja;
        rst_n     = 1'b0;
        run       = 1'b0;
        ir_ready  = 1'b0;
        jump_req  = 1'b0;
        jump_addr = '0;
        halt      = 1'b0;
        modelReset();
        #2;
        checkOutput("initial rom_addr", 32'(rom_addr), 32'h0);
        checkOutput("initial ir_valid", 32'(ir_valid), 32'h0);
        checkOutput("initial halted", 32'(halted), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] straight-line fetch");
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, '0, 0);

        $display("[TB] decode stall and release");
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, '0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, '0, 0);

        $display("[TB] jump to 16 at pc 5");
        doReset();
        for (int i = 0; i < 20 && m_pc != 16'd5; i++) applyStimulus(1, 1, 0, '0, 0);
        checkOutput("reached pc 5", 32'(rom_addr), 32'd5);
        applyStimulus(1, 1, 1, 16'd16, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, '0, 0);

        $display("[TB] jump to top of address space and wrap");
        applyStimulus(1, 1, 1, 16'hFFFF, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, '0, 0);

        $display("[TB] halt with simultaneous jump");
        applyStimulus(1, 1, 1, 16'h1234, 1);
        for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, '0, 0);

        $display("[TB] reset during stall");
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, '0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, '0, 0);
        checkOutput("stall before reset", 32'(ir_valid), 32'h1);
        doReset();

        $display("[TB] randomised traffic");
        for (int i = 0; i < 800; i++) begin
            if (i % 160 == 159) begin
                doReset();
            end else begin
                ja = ($urandom_range(0, 3) == 0) ? AW'(16'hFFFD + $urandom_range(0, 2)) : AW'($urandom);
                applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0,
                              $urandom_range(0, 11) == 0, ja, $urandom_range(0, 199) == 0);
            end
        end

        checkOutput("scoreboard drained", 32'(expected_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
